// File: rtl/led_shift_ctrl_pkg.sv
// Shared constants and types for the LED shift controller.
// The mode encoding matches the board's two-position sw_mode switches.
package led_shift_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROT    = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  localparam logic DIR_LEFT = 1'b1;

  // Resolved button request for one cycle; simultaneous left+right resolves to ACT_NONE
  typedef enum logic [1:0] {
    ACT_NONE  = 2'b00,
    ACT_LEFT  = 2'b01,
    ACT_RIGHT = 2'b10
  } act_e;

  function automatic act_e resolve_act(input logic left_press, input logic right_press);
    act_e act;
    act = ACT_NONE;
    if (left_press && !right_press) begin
      act = ACT_LEFT;
    end else if (right_press && !left_press) begin
      act = ACT_RIGHT;
    end
    return act;
  endfunction

endpackage

// File: rtl/led_shift_ctrl_btn_sync.sv
// Button synchroniser and press-pulse generator for one active-low push button.
// With LEDSHIFT_DEBOUNCE_EN defined, an accepted-state debounce filter sits after the first flop.
module btn_sync
  import led_shift_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  logic s1;

`ifdef LEDSHIFT_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          acc;
  logic          acc_d;

  // acc only follows s1 after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b1;
      cnt   <= '0;
      acc   <= 1'b1;
      acc_d <= 1'b1;
    end else begin
      s1    <= btn_n;
      acc_d <= acc;
      if (s1 == acc) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        acc <= s1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = ~acc;
  assign press = acc_d & ~acc;
`else
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end

  assign level = ~s2;
  assign press = s2 & ~s1;
`endif

endmodule

// File: rtl/led_shift_ctrl.sv
// LED pattern controller: manual shift/rotate plus auto marquee and ping-pong bounce.
// Optional button debounce is enabled by defining LEDSHIFT_DEBOUNCE_EN.
module led_shift_ctrl
  import led_shift_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int TICK_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_clr_n,
  input  logic             btn_left_n,
  input  logic             btn_right_n,
  input  logic             sw_fill_l,
  input  logic             sw_fill_r,
  input  logic [1:0]       sw_mode,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             dir_left
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic clr_level;
  logic clr_press_unused;
  logic left_level_unused;
  logic left_press;
  logic right_level_unused;
  logic right_press;

  btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_clr (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_clr_n),
    .level (clr_level),
    .press (clr_press_unused)
  );

  btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_left (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_left_n),
    .level (left_level_unused),
    .press (left_press)
  );

  btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_right (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_right_n),
    .level (right_level_unused),
    .press (right_press)
  );

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  logic [PW-1:0]    presc;
  act_e             act;
  logic             is_auto;
  logic             is_bounce;
  logic             act_left;
  logic [WIDTH-1:0] manual_left;
  logic [WIDTH-1:0] manual_right;
  logic [WIDTH-1:0] step_led;
  logic             step_dir;

  always_comb begin
    act       = resolve_act(left_press, right_press);
    act_left  = (act == ACT_LEFT);
    is_auto   = (sw_mode == MODE_AUTO) || (sw_mode == MODE_BOUNCE);
    is_bounce = (sw_mode == MODE_BOUNCE);
  end

  always_comb begin
    manual_left  = rot_left(led);
    manual_right = rot_right(led);
    if (sw_mode == MODE_SHIFT) begin
      manual_left  = {led[WIDTH-2:0], sw_fill_l};
      manual_right = {sw_fill_r, led[WIDTH-1:1]};
    end
  end

  // One auto step: empty pattern is seeded at the end it will travel away from
  always_comb begin
    step_dir = dir_left;
    step_led = dir_left ? rot_left(led) : rot_right(led);
    if (led == '0) begin
      step_led = dir_left ? WIDTH'(1) : {1'b1, {(WIDTH-1){1'b0}}};
    end else if (is_bounce && dir_left && led[WIDTH-1]) begin
      step_dir = ~DIR_LEFT;
      step_led = rot_right(led);
    end else if (is_bounce && !dir_left && led[0]) begin
      step_dir = DIR_LEFT;
      step_led = rot_left(led);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '0;
      running  <= 1'b0;
      dir_left <= DIR_LEFT;
      presc    <= '0;
    end else if (clr_level) begin
      led     <= '0;
      running <= 1'b0;
      presc   <= '0;
    end else if (!is_auto) begin
      running <= 1'b0;
      case (act)
        ACT_LEFT:  led <= manual_left;
        ACT_RIGHT: led <= manual_right;
        default:   ;
      endcase
    end else if (act != ACT_NONE) begin
      // Same direction pauses/resumes; opposite direction restarts that way
      if ((act_left ? DIR_LEFT : ~DIR_LEFT) == dir_left) begin
        running <= ~running;
      end else begin
        dir_left <= act_left ? DIR_LEFT : ~DIR_LEFT;
        running  <= 1'b1;
      end
      presc <= '0;
    end else if (running) begin
      if (presc == PRESC_LAST) begin
        presc    <= '0;
        led      <= step_led;
        dir_left <= step_dir;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule
